dcache_assoc: RTL and testbench

//  Blocking, write-back, write-allocate N-way set-associative data cache between the LSU (ex stage) and the tagged Dmem bus.

---
 rtl/dcache_assoc_if.sv | 41 ++++
 rtl/dcache_assoc.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_assoc_if.sv
// LSU-side request/response bundle and Dmem-side bus bundle for the
// set-associative data cache. The cache is the slave on the LSU side and
// the master on the memory side.
interface dcache_assoc_if;
  logic [1:0]  proc2Dcache_command;
  logic [31:0] proc2Dcache_addr;
  logic [63:0] proc2Dcache_data;
  logic [1:0]  mem_size;
  logic        flush;
  logic        Dcache_ready;
  logic        Dcache_valid_out;
  logic [63:0] Dcache_data_out;
  logic        flush_done;

  modport master (
    output proc2Dcache_command, proc2Dcache_addr, proc2Dcache_data, mem_size, flush,
    input  Dcache_ready, Dcache_valid_out, Dcache_data_out, flush_done
  );
  modport slave (
    input  proc2Dcache_command, proc2Dcache_addr, proc2Dcache_data, mem_size, flush,
    output Dcache_ready, Dcache_valid_out, Dcache_data_out, flush_done
  );
endinterface

interface dcache_mem_if;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
  );
  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
  );
endinterface

// File: rtl/dcache_assoc.sv
// Blocking write-back / write-allocate N-way set-associative data cache with
// true-LRU replacement, byte/half/word/double lane access and a full flush.
// Line data and tags carry no reset; only valid/dirty/age and the FSM do.
module dcache_assoc #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int ADDR_BITS = 16
) (
  input logic           clock,
  input logic           reset,
  dcache_assoc_if.slave lsu,
  dcache_mem_if.master  mem
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = ADDR_BITS - 3 - IDX;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_FILL_REQ, S_FILL_WAIT, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  logic [63:0]     line_data  [SETS][WAYS];
  logic [TAGW-1:0] line_tag   [SETS][WAYS];
  logic            line_valid [SETS][WAYS];
  logic            line_dirty [SETS][WAYS];
  logic [WW-1:0]   line_age   [SETS][WAYS];

  state_t                 state;
  logic [1:0]             req_cmd;
  logic [ADDR_BITS-1:0]   req_addr;
  logic [63:0]            req_data;
  logic [1:0]             req_size;
  logic [WW-1:0]          victim;
  logic [3:0]             mem_tag;
  logic [IDX-1:0]         scan_set;
  logic [WW-1:0]          scan_way;
  logic                   ready_r, valid_r, flush_done_r;
  logic [63:0]            data_out_r, mem_data_r;
  logic [1:0]             mem_cmd_r;
  logic [31:0]            mem_addr_r;

  // Offset bits below the access size are dropped so every access is aligned.
  function automatic logic [2:0] align(input logic [2:0] off, input logic [1:0] size);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[2:1], 1'b0};
      SZ_WORD: return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [63:0] lane_read(input logic [63:0] line, input logic [2:0] off,
                                            input logic [1:0] size);
    case (size)
      SZ_BYTE: return {56'd0, line[{off, 3'b000} +: 8]};
      SZ_HALF: return {48'd0, line[{off[2:1], 4'b0000} +: 16]};
      SZ_WORD: return {32'd0, line[{off[2], 5'b00000} +: 32]};
      default: return line;
    endcase
  endfunction

  function automatic logic [63:0] lane_merge(input logic [63:0] line, input logic [63:0] wdata,
                                             input logic [2:0] off, input logic [1:0] size);
    logic [63:0] r;
    r = line;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8]         = wdata[7:0];
      SZ_HALF: r[{off[2:1], 4'b0000} +: 16]  = wdata[15:0];
      SZ_WORD: r[{off[2], 5'b00000} +: 32]   = wdata[31:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] line_addr(input logic [TAGW-1:0] t, input logic [IDX-1:0] i);
    return 32'({t, i, 3'b000});
  endfunction

  logic [2:0]      req_off;
  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  assign req_off = align(req_addr[2:0], req_size);
  assign req_idx = req_addr[3 +: IDX];
  assign req_tag = req_addr[3 + IDX +: TAGW];

  logic scan_last;
  assign scan_last = (scan_set == IDX'(SETS - 1)) && (scan_way == WW'(WAYS - 1));

  logic unused_addr_hi;
  assign unused_addr_hi = ^lsu.proc2Dcache_addr[31:ADDR_BITS];

  logic          hit;
  logic [WW-1:0] hit_way;
  // Tag match across the ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (line_valid[req_idx][w] && line_tag[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  logic          vic_found;
  logic [WW-1:0] vic_way;
  // Victim choice: lowest invalid way first, otherwise the oldest way.
  always_comb begin
    vic_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !line_valid[req_idx][w]) begin
        vic_way   = WW'(w);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (line_age[req_idx][w] == WW'(WAYS - 1)) vic_way = WW'(w);
      end
    end
  end

  // Cache controller: FSM, registered outputs, and array updates.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      ready_r      <= 1'b1;
      valid_r      <= 1'b0;
      data_out_r   <= '0;
      flush_done_r <= 1'b0;
      mem_cmd_r    <= BUS_NONE;
      mem_addr_r   <= '0;
      mem_data_r   <= '0;
      mem_tag      <= '0;
      victim       <= '0;
      scan_set     <= '0;
      scan_way     <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          line_valid[s][w] <= 1'b0;
          line_dirty[s][w] <= 1'b0;
          line_age[s][w]   <= WW'(w);
        end
      end
    end else begin
      valid_r      <= 1'b0;
      flush_done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lsu.flush) begin
            ready_r  <= 1'b0;
            scan_set <= '0;
            scan_way <= '0;
            state    <= S_FLUSH_SCAN;
          end else if (lsu.proc2Dcache_command != BUS_NONE) begin
            ready_r  <= 1'b0;
            req_cmd  <= lsu.proc2Dcache_command;
            req_addr <= lsu.proc2Dcache_addr[ADDR_BITS-1:0];
            req_data <= lsu.proc2Dcache_data;
            req_size <= lsu.mem_size;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (req_cmd == BUS_STORE) begin
              line_data[req_idx][hit_way]  <= lane_merge(line_data[req_idx][hit_way], req_data,
                                                         req_off, req_size);
              line_dirty[req_idx][hit_way] <= 1'b1;
            end else begin
              data_out_r <= lane_read(line_data[req_idx][hit_way], req_off, req_size);
            end
            if (WAYS > 1) begin
              for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == hit_way)
                  line_age[req_idx][w] <= '0;
                else if (line_age[req_idx][w] < line_age[req_idx][hit_way])
                  line_age[req_idx][w] <= line_age[req_idx][w] + 1'b1;
              end
            end
            valid_r <= 1'b1;
            ready_r <= 1'b1;
            state   <= S_IDLE;
          end else begin
            victim <= vic_way;
            if (line_valid[req_idx][vic_way] && line_dirty[req_idx][vic_way]) begin
              mem_cmd_r  <= BUS_STORE;
              mem_addr_r <= line_addr(line_tag[req_idx][vic_way], req_idx);
              mem_data_r <= line_data[req_idx][vic_way];
              state      <= S_EVICT;
            end else begin
              mem_cmd_r  <= BUS_LOAD;
              mem_addr_r <= line_addr(req_tag, req_idx);
              state      <= S_FILL_REQ;
            end
          end
        end
        S_EVICT: begin
          if (mem.Dmem2proc_response != 4'd0) begin
            line_dirty[req_idx][victim] <= 1'b0;
            mem_cmd_r  <= BUS_LOAD;
            mem_addr_r <= line_addr(req_tag, req_idx);
            state      <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          if (mem.Dmem2proc_response != 4'd0) begin
            mem_tag   <= mem.Dmem2proc_response;
            mem_cmd_r <= BUS_NONE;
            state     <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          // The replayed lookup is a guaranteed hit and updates LRU there.
          if (mem_tag != 4'd0 && mem.Dmem2proc_tag == mem_tag) begin
            line_data[req_idx][victim]  <= mem.Dmem2proc_data;
            line_tag[req_idx][victim]   <= req_tag;
            line_valid[req_idx][victim] <= 1'b1;
            line_dirty[req_idx][victim] <= 1'b0;
            state <= S_LOOKUP;
          end
        end
        S_FLUSH_SCAN: begin
          if (line_valid[scan_set][scan_way] && line_dirty[scan_set][scan_way]) begin
            mem_cmd_r  <= BUS_STORE;
            mem_addr_r <= line_addr(line_tag[scan_set][scan_way], scan_set);
            mem_data_r <= line_data[scan_set][scan_way];
            state      <= S_FLUSH_WB;
          end else if (scan_last) begin
            flush_done_r <= 1'b1;
            ready_r      <= 1'b1;
            state        <= S_IDLE;
          end else if (scan_way == WW'(WAYS - 1)) begin
            scan_way <= '0;
            scan_set <= scan_set + 1'b1;
          end else begin
            scan_way <= scan_way + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          if (mem.Dmem2proc_response != 4'd0) begin
            line_dirty[scan_set][scan_way] <= 1'b0;
            mem_cmd_r <= BUS_NONE;
            if (scan_last) begin
              flush_done_r <= 1'b1;
              ready_r      <= 1'b1;
              state        <= S_IDLE;
            end else begin
              if (scan_way == WW'(WAYS - 1)) begin
                scan_way <= '0;
                scan_set <= scan_set + 1'b1;
              end else begin
                scan_way <= scan_way + 1'b1;
              end
              state <= S_FLUSH_SCAN;
            end
          end
        end
        default: begin
          ready_r <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign lsu.Dcache_ready      = ready_r;
  assign lsu.Dcache_valid_out  = valid_r;
  assign lsu.Dcache_data_out   = data_out_r;
  assign lsu.flush_done        = flush_done_r;
  assign mem.proc2Dmem_command = mem_cmd_r;
  assign mem.proc2Dmem_addr    = mem_addr_r;
  assign mem.proc2Dmem_data    = mem_data_r;
endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: directed LSU requests push expected
// responses and bus transactions; a memory model and a response monitor
// pop and compare them independently of the stimulus.
module tb_dcache_assoc;
  localparam logic [1:0] NONE = 2'd0, LD = 2'd1, ST = 2'd2;
  localparam logic [1:0] SZB = 2'd0, SZH = 2'd1, SZW = 2'd2, SZD = 2'd3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  // Free-running cycle counter used for latency measurement.
  always @(posedge clock) cyc <= cyc + 1;

  dcache_assoc_if lsu ();
  dcache_mem_if   mem ();

  dcache_assoc #(.WAYS(2), .SETS(16), .ADDR_BITS(16)) dut (
    .clock (clock),
    .reset (reset),
    .lsu   (lsu),
    .mem   (mem)
  );

  typedef struct { logic [1:0] cmd; logic [63:0] data; int lat; } resp_t;
  typedef struct { logic [1:0] cmd; logic [31:0] addr; logic [63:0] data; } bus_t;

  resp_t       resp_q[$];
  bus_t        bus_q[$];
  logic [63:0] fill_q[$];

  int checks = 0, errors = 0;
  int acc_cyc = 0;
  int stall = 0;
  int fill_delay = 2;
  logic [3:0] resp_tag = 4'd1;
  logic [3:0] bogus_tag = 4'd0;
  int stores_seen = 0;
  int flush_done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory model: stalls on request, checks accepted transactions, returns fills.
  initial begin
    logic        pend;
    bus_t        last, cur, exp;
    int          fill_cnt;
    logic [3:0]  ftag;
    logic [63:0] fdata;
    pend = 1'b0;
    fill_cnt = 0;
    ftag = 4'd0;
    fdata = 64'd0;
    mem.Dmem2proc_response = 4'd0;
    mem.Dmem2proc_tag = 4'd0;
    mem.Dmem2proc_data = 64'd0;
    forever begin
      @(negedge clock);
      mem.Dmem2proc_response = 4'd0;
      mem.Dmem2proc_tag = 4'd0;
      mem.Dmem2proc_data = 64'd0;
      if (fill_cnt > 0) begin
        fill_cnt--;
        if (fill_cnt == 0) begin
          mem.Dmem2proc_tag = ftag;
          mem.Dmem2proc_data = fdata;
        end else if (fill_cnt == 1 && bogus_tag != 4'd0) begin
          mem.Dmem2proc_tag = bogus_tag;
          mem.Dmem2proc_data = 64'hDEAD_BEEF_DEAD_BEEF;
        end
      end
      cur = '{mem.proc2Dmem_command, mem.proc2Dmem_addr, mem.proc2Dmem_data};
      if (cur.cmd != NONE) begin
        if (pend) begin
          chk("hold_cmd", 64'(cur.cmd), 64'(last.cmd));
          chk("hold_addr", 64'(cur.addr), 64'(last.addr));
          chk("hold_data", cur.data, last.data);
        end
        if (stall > 0) begin
          stall--;
          pend = 1'b1;
          last = cur;
        end else begin
          pend = 1'b0;
          mem.Dmem2proc_response = resp_tag;
          if (bus_q.size() == 0) begin
            flag("bus_unexpected");
          end else begin
            exp = bus_q.pop_front();
            chk("bus_cmd", 64'(cur.cmd), 64'(exp.cmd));
            chk("bus_addr", 64'(cur.addr), 64'(exp.addr));
            if (exp.cmd == ST) chk("bus_wb_data", cur.data, exp.data);
          end
          if (cur.cmd == ST) stores_seen++;
          if (cur.cmd == LD) begin
            if (fill_q.size() == 0) fdata = 64'd0;
            else fdata = fill_q.pop_front();
            ftag = resp_tag;
            fill_cnt = fill_delay;
          end
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Response monitor: every valid_out pops one expected response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clock);
      if (lsu.Dcache_valid_out) begin
        if (resp_q.size() == 0) begin
          flag("valid_unexpected");
        end else begin
          r = resp_q.pop_front();
          if (r.cmd == LD) chk("load_data", lsu.Dcache_data_out, r.data);
          if (r.lat > 0) chk("hit_latency", 64'(cyc - acc_cyc), 64'(r.lat));
        end
      end
      if (lsu.flush_done) flush_done_cnt++;
    end
  end

  task automatic do_req(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic [63:0] exp_data, input int lat,
                        input bit want);
    int n;
    n = 0;
    @(negedge clock);
    while (!lsu.Dcache_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!lsu.Dcache_ready) begin
      flag("ready_timeout");
      return;
    end
    if (want) resp_q.push_back('{cmd, exp_data, lat});
    lsu.proc2Dcache_command = cmd;
    lsu.proc2Dcache_addr = addr;
    lsu.proc2Dcache_data = wdata;
    lsu.mem_size = size;
    acc_cyc = cyc;
    @(negedge clock);
    lsu.proc2Dcache_command = NONE;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(resp_q.size() == 0 && bus_q.size() == 0 && lsu.Dcache_ready) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      flag(name);
      resp_q.delete();
      bus_q.delete();
      fill_q.delete();
    end
  endtask

  initial begin
    int n, st0, fd0;
    lsu.proc2Dcache_command = NONE;
    lsu.proc2Dcache_addr = 32'd0;
    lsu.proc2Dcache_data = 64'd0;
    lsu.mem_size = SZD;
    lsu.flush = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready", 64'(lsu.Dcache_ready), 64'd1);
    chk("rst_valid", 64'(lsu.Dcache_valid_out), 64'd0);
    chk("rst_data_out", lsu.Dcache_data_out, 64'd0);
    chk("rst_flush_done", 64'(lsu.flush_done), 64'd0);
    chk("rst_mem_cmd", 64'(mem.proc2Dmem_command), 64'(NONE));
    chk("rst_mem_addr", 64'(mem.proc2Dmem_addr), 64'd0);
    reset = 1'b1;

    // Cold miss on a double, fill, replayed hit.
    bus_q.push_back('{LD, 32'h40, 64'd0});
    fill_q.push_back(64'h1122334455667788);
    do_req(LD, 32'h40, 64'd0, SZD, 64'h1122334455667788, 0, 1'b1);
    wait_done("t1_timeout");

    // Byte hit: no bus traffic, fixed latency.
    do_req(LD, 32'h43, 64'd0, SZB, 64'h55, 2, 1'b1);
    wait_done("t2_timeout");

    // Half store merge then full-line readback.
    do_req(ST, 32'h42, 64'hBEEF, SZH, 64'd0, 0, 1'b1);
    wait_done("t3a_timeout");
    do_req(LD, 32'h40, 64'd0, SZD, 64'h11223344BEEF7788, 0, 1'b1);
    wait_done("t3b_timeout");

    // Second way of set 8, then a word hit on it.
    bus_q.push_back('{LD, 32'hC0, 64'd0});
    fill_q.push_back(64'hA5A5A5A55A5A5A5A);
    do_req(LD, 32'hC0, 64'd0, SZD, 64'hA5A5A5A55A5A5A5A, 0, 1'b1);
    wait_done("t4a_timeout");
    do_req(LD, 32'hC4, 64'd0, SZW, 64'hA5A5A5A5, 0, 1'b1);
    wait_done("t4b_timeout");

    // LRU victim is the dirty 0x40 line: stalled writeback, bogus fill tag ignored.
    stall = 3;
    resp_tag = 4'd5;
    bogus_tag = 4'd3;
    bus_q.push_back('{ST, 32'h40, 64'h11223344BEEF7788});
    bus_q.push_back('{LD, 32'h140, 64'd0});
    fill_q.push_back(64'h0123456789ABCDEF);
    do_req(LD, 32'h140, 64'd0, SZD, 64'h0123456789ABCDEF, 0, 1'b1);
    wait_done("t5_timeout");
    resp_tag = 4'd1;
    bogus_tag = 4'd0;

    // Two dirty lines, then flush writes back exactly those two.
    do_req(ST, 32'hC4, 64'hCAFEF00D, SZW, 64'd0, 0, 1'b1);
    wait_done("t6a_timeout");
    bus_q.push_back('{LD, 32'h08, 64'd0});
    fill_q.push_back(64'h1111111111111111);
    do_req(ST, 32'h0F, 64'h99, SZB, 64'd0, 0, 1'b1);
    wait_done("t6b_timeout");
    bus_q.push_back('{ST, 32'h08, 64'h9911111111111111});
    bus_q.push_back('{ST, 32'hC0, 64'hCAFEF00D5A5A5A5A});
    st0 = stores_seen;
    fd0 = flush_done_cnt;
    @(negedge clock);
    lsu.flush = 1'b1;
    @(negedge clock);
    lsu.flush = 1'b0;
    n = 0;
    while (flush_done_cnt == fd0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("flush_done_seen", 64'(flush_done_cnt - fd0), 64'd1);
    chk("flush_stores", 64'(stores_seen - st0), 64'd2);
    repeat (4) @(negedge clock);
    chk("flush_done_pulse", 64'(flush_done_cnt - fd0), 64'd1);
    chk("flush_ready", 64'(lsu.Dcache_ready), 64'd1);
    do_req(LD, 32'hC0, 64'd0, SZD, 64'hCAFEF00D5A5A5A5A, 0, 1'b1);
    wait_done("t6c_timeout");

    // Reset while waiting for a fill; the late fill must be ignored.
    fill_delay = 6;
    resp_tag = 4'd7;
    bus_q.push_back('{LD, 32'h200, 64'd0});
    fill_q.push_back(64'h7777777777777777);
    do_req(LD, 32'h200, 64'd0, SZD, 64'd0, 0, 1'b0);
    n = 0;
    while (bus_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (bus_q.size() != 0) flag("t7_fill_req_timeout");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("midrst_ready", 64'(lsu.Dcache_ready), 64'd1);
    chk("midrst_mem_cmd", 64'(mem.proc2Dmem_command), 64'(NONE));
    repeat (10) @(negedge clock);
    chk("late_tag_ready", 64'(lsu.Dcache_ready), 64'd1);
    fill_delay = 2;
    resp_tag = 4'd1;
    bus_q.push_back('{LD, 32'h40, 64'd0});
    fill_q.push_back(64'h5555666677778888);
    do_req(LD, 32'h40, 64'd0, SZD, 64'h5555666677778888, 0, 1'b1);
    wait_done("t7_timeout");

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
